// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller with level/edge gateways, priority arbitration and claim/complete.
//   i_clk/i_rst_n          clock, synchronous active-low reset
//   i_irq_src              raw interrupt sources
//   i_cfg_we/addr/wdata    config write: addr<N_SRC priority, N_SRC enable mask, N_SRC+1 threshold
//   o_cfg_rdata            combinational readback of i_cfg_addr (unmapped reads 0)
//   i_claim/o_claim_vld/o_claim_id   claim pulse and registered response (ID 0 = none)
//   i_complete/i_complete_id         completion pulse releasing an in-service source
//   o_pending/o_irq        pending bits and registered interrupt request
//   IRQ_SYNC_EN defined: sources pass a 2-flop synchroniser before the gateway.
module irq_ctrl #(
   parameter int               N_SRC     = 8,
   parameter int               PRIO_W    = 3,
   parameter logic [N_SRC-1:0] EDGE_MASK = '0,
   parameter int               ID_W      = $clog2(N_SRC + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_SRC-1:0]  i_irq_src,
   input  logic              i_cfg_we,
   input  logic [4:0]        i_cfg_addr,
   input  logic [31:0]       i_cfg_wdata,
   output logic [31:0]       o_cfg_rdata,
   input  logic              i_claim,
   output logic              o_claim_vld,
   output logic [ID_W-1:0]   o_claim_id,
   input  logic              i_complete,
   input  logic [ID_W-1:0]   i_complete_id,
   output logic [N_SRC-1:0]  o_pending,
   output logic              o_irq
);
   logic [PRIO_W-1:0] r_prio [N_SRC];
   logic [N_SRC-1:0]  r_en, r_pend, r_ins, r_src_q;
   logic [PRIO_W-1:0] r_thr;
   logic              r_irq, r_claim_vld;
   logic [ID_W-1:0]   r_claim_id;
   logic [N_SRC-1:0]  w_src, w_set, w_elig, w_win_oh, w_cmp_oh, w_clr;
   logic [ID_W-1:0]   w_win_id;
   logic [PRIO_W-1:0] w_best;
   logic              w_unused;

`ifdef IRQ_SYNC_EN
   logic [N_SRC-1:0] r_sync1, r_sync2;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_irq_src;
         r_sync2 <= r_sync1;
      end
   end
   assign w_src = r_sync2;
`else
   assign w_src = i_irq_src;
`endif

   assign w_unused = &{1'b0, i_cfg_wdata};
   // Gateway: sources already in service cannot re-pend until completed.
   assign w_set = ((w_src & ~r_src_q & EDGE_MASK) | (w_src & ~EDGE_MASK)) & ~r_ins;
   assign w_clr = i_claim ? w_win_oh : '0;

   always_comb begin
      w_best   = '0;
      w_win_id = '0;
      w_win_oh = '0;
      w_cmp_oh = '0;
      w_elig   = '0;
      o_cfg_rdata = '0;
      for (int n = 0; n < N_SRC; n++) begin
         w_elig[n] = r_pend[n] & r_en[n] & ~r_ins[n] & (r_prio[n] > r_thr);
         // Strictly-greater keeps the lowest index on priority ties.
         if (w_elig[n] && r_prio[n] > w_best) begin
            w_best   = r_prio[n];
            w_win_id = ID_W'(n + 1);
            w_win_oh = '0;
            w_win_oh[n] = 1'b1;
         end
         if (i_complete && i_complete_id == ID_W'(n + 1)) w_cmp_oh[n] = 1'b1;
         if (i_cfg_addr == 5'(n)) o_cfg_rdata = 32'(r_prio[n]);
      end
      if (i_cfg_addr == 5'(N_SRC)) o_cfg_rdata = 32'(r_en);
      if (i_cfg_addr == 5'(N_SRC + 1)) o_cfg_rdata = 32'(r_thr);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int n = 0; n < N_SRC; n++) r_prio[n] <= '0;
         r_en        <= '0;
         r_thr       <= '0;
         r_pend      <= '0;
         r_ins       <= '0;
         r_src_q     <= '0;
         r_irq       <= 1'b0;
         r_claim_vld <= 1'b0;
         r_claim_id  <= '0;
      end else begin
         if (i_cfg_we) begin
            for (int n = 0; n < N_SRC; n++)
               if (i_cfg_addr == 5'(n)) r_prio[n] <= i_cfg_wdata[PRIO_W-1:0];
            if (i_cfg_addr == 5'(N_SRC)) r_en <= i_cfg_wdata[N_SRC-1:0];
            if (i_cfg_addr == 5'(N_SRC + 1)) r_thr <= i_cfg_wdata[PRIO_W-1:0];
         end
         r_src_q     <= w_src;
         r_pend      <= (r_pend & ~w_clr) | w_set;
         r_ins       <= (r_ins & ~w_cmp_oh) | w_clr;
         r_irq       <= |w_elig;
         r_claim_vld <= i_claim;
         r_claim_id  <= i_claim ? w_win_id : '0;
      end
   end

   assign o_pending   = r_pend;
   assign o_irq       = r_irq;
   assign o_claim_vld = r_claim_vld;
   assign o_claim_id  = r_claim_id;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed checks of irq_ctrl gateway, arbitration, claim/complete, config and reset.
module tb_irq_ctrl;
`ifdef IRQ_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif
   logic        clk = 0, rst_n = 0;
   logic [7:0]  src = '0;
   logic        cfg_we = 0;
   logic [4:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0, cfg_rdata;
   logic        claim = 0, claim_vld, complete = 0, irq;
   logic [3:0]  claim_id, complete_id = '0;
   logic [7:0]  pending;
   int checks = 0, errors = 0, n;

   irq_ctrl #(.N_SRC(8), .PRIO_W(3), .EDGE_MASK(8'h20)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_irq_src(src),
      .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata), .o_cfg_rdata(cfg_rdata),
      .i_claim(claim), .o_claim_vld(claim_vld), .o_claim_id(claim_id),
      .i_complete(complete), .i_complete_id(complete_id),
      .o_pending(pending), .o_irq(irq));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [4:0] a, input logic [31:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 0;
   endtask

   task automatic pulse(input logic [7:0] m);
      src = m;
      tick();
      src = '0;
      repeat (SD) tick();
   endtask

   task automatic do_claim(input string tag, input logic [3:0] exp);
      claim = 1;
      tick();
      claim = 0;
      chk({tag, "_vld"}, 32'(claim_vld), 1);
      chk({tag, "_id"}, 32'(claim_id), 32'(exp));
   endtask

   task automatic do_complete(input logic [3:0] id);
      complete = 1; complete_id = id;
      tick();
      complete = 0; complete_id = '0;
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_irq", 32'(irq), 0);
      chk("rst_vld", 32'(claim_vld), 0);
      chk("rst_id", 32'(claim_id), 0);
      chk("rst_pend", 32'(pending), 0);
      cfg_addr = 5'd8; #1;
      chk("rst_en", cfg_rdata, 0);
      rst_n = 1;
      // level source 3
      cfg(5'd3, 2); cfg(5'd8, 32'h08); cfg(5'd9, 0);
      cfg_addr = 5'd3; #1;
      chk("rd_prio3", cfg_rdata, 2);
      pulse(8'h08);
      chk("t1_pend", 32'(pending), 32'h08);
      chk("t1_irq_lat", 32'(irq), 0);
      tick();
      chk("t1_irq", 32'(irq), 1);
      do_claim("t1_claim", 4);
      chk("t1_pend_clr", 32'(pending), 0);
      tick();
      chk("t1_irq_drop", 32'(irq), 0);
      chk("t1_vld_drop", 32'(claim_vld), 0);
      do_complete(4);
      // arbitration
      cfg(5'd1, 5); cfg(5'd6, 5); cfg(5'd2, 7); cfg(5'd8, 32'hff);
      pulse(8'h46);
      tick();
      chk("t2_irq", 32'(irq), 1);
      do_claim("t2_c1", 3);
      do_claim("t2_c2", 2);
      do_claim("t2_c3", 7);
      do_claim("t2_c4", 0);
      chk("t2_irq_off", 32'(irq), 0);
      do_complete(3); do_complete(2); do_complete(7);
      // threshold
      cfg(5'd9, 4); cfg(5'd0, 4);
      src = 8'h01;
      repeat (SD + 2) tick();
      chk("t3_pend", 32'(pending), 32'h01);
      chk("t3_irq_thr", 32'(irq), 0);
      cfg(5'd9, 3);
      tick();
      chk("t3_irq_on", 32'(irq), 1);
      cfg(5'd9, 4);
      tick();
      chk("t3_irq_drop", 32'(irq), 0);
      cfg(5'd9, 3);
      cfg_addr = 5'd9; #1;
      chk("rd_thr", cfg_rdata, 3);
      cfg_addr = 5'd20; #1;
      chk("rd_unmapped", cfg_rdata, 0);
      tick();
      chk("t3_irq_back", 32'(irq), 1);
      src = '0;
      repeat (SD) tick();
      do_claim("t3_claim", 1);
      do_complete(1);
      cfg(5'd9, 0);
      // edge source 5
      cfg(5'd5, 6);
      pulse(8'h20);
      chk("t4_pend", 32'(pending), 32'h20);
      tick();
      chk("t4_irq", 32'(irq), 1);
      do_claim("t4_claim", 6);
      pulse(8'h20);
      chk("t4_blocked", 32'(pending), 0);
      tick();
      chk("t4_irq_off", 32'(irq), 0);
      do_complete(0);
      do_complete(9);
      pulse(8'h20);
      chk("t5_ignored", 32'(pending), 0);
      do_complete(6);
      pulse(8'h20);
      chk("t4_repend", 32'(pending), 32'h20);
      tick();
      do_claim("t4_reclaim", 6);
      pulse(8'h08);
      chk("t5_pend3", 32'(pending), 32'h08);
      tick();
      chk("t5_irq", 32'(irq), 1);
      // reset mid-service
      rst_n = 0; claim = 1;
      tick();
      claim = 0; rst_n = 1;
      chk("rst2_irq", 32'(irq), 0);
      chk("rst2_vld", 32'(claim_vld), 0);
      chk("rst2_id", 32'(claim_id), 0);
      chk("rst2_pend", 32'(pending), 0);
      cfg_addr = 5'd3; #1;
      chk("rst2_prio", cfg_rdata, 0);
      cfg(5'd5, 6); cfg(5'd8, 32'h20);
      pulse(8'h20);
      chk("rst2_ins_clr", 32'(pending), 32'h20);
      tick();
      do_claim("rst2_claim", 6);
      // latency
      cfg(5'd2, 1); cfg(5'd8, 32'h04);
      src = 8'h04;
      tick();
      n = 0;
      while (!irq && n < 10) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'(SD + 1));
      src = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
